// File: rtl/psum_accum.sv
// Signed dot-product accumulator with round / shift / ReLU / saturate requantization
// and a registered valid/ready output stage.
module psum_accum #(
    parameter int A_width   = 8,
    parameter int B_width   = 8,
    parameter int ACC_width = 32,
    parameter int OUT_width = 8,
    parameter int SH_width  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [A_width+B_width-1:0]   product,
    input  logic                         last,
    input  logic [SH_width-1:0]          shift,
    input  logic                         relu,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_width-1:0]         out_data,
    output logic                         out_sat
);

    localparam int P = A_width + B_width;
    localparam int W = ACC_width + 1;

    localparam logic signed [ACC_width-1:0] ACC_MAX = {1'b0, {(ACC_width-1){1'b1}}};
    localparam logic signed [ACC_width-1:0] ACC_MIN = {1'b1, {(ACC_width-1){1'b0}}};
    localparam logic signed [W-1:0] OUT_MAX_W = {{(W-OUT_width+1){1'b0}}, {(OUT_width-1){1'b1}}};
    localparam logic signed [W-1:0] OUT_MIN_W = {{(W-OUT_width+1){1'b1}}, {(OUT_width-1){1'b0}}};
    localparam logic [OUT_width-1:0] OUT_MAX = {1'b0, {(OUT_width-1){1'b1}}};
    localparam logic [OUT_width-1:0] OUT_MIN = {1'b1, {(OUT_width-1){1'b0}}};

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t                       state;
    logic signed [ACC_width-1:0]  acc;
    logic                         acc_ovf;

    logic                         accept;
    logic signed [ACC_width-1:0]  acc_base;
    logic                         ovf_base;
    logic signed [W-1:0]          sum_wide;
    logic                         sum_ovf;
    logic signed [ACC_width-1:0]  sum_sat;
    logic signed [W-1:0]          sum_ext;
    logic signed [W-1:0]          round_term;
    logic signed [W-1:0]          r_shift;
    logic signed [W-1:0]          r_relu;
    logic                         clamp_hi;
    logic                         clamp_lo;
    logic [OUT_width-1:0]         res_data;
    logic                         res_sat;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // A fresh dot product starts from zero regardless of leftover acc contents.
        acc_base = (state == BUSY) ? acc : '0;
        ovf_base = (state == BUSY) & acc_ovf;

        sum_wide = {acc_base[ACC_width-1], acc_base} + {{(W-P){product[P-1]}}, product};
        sum_ovf  = sum_wide[W-1] ^ sum_wide[W-2];
        if (sum_ovf) begin
            sum_sat = sum_wide[W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_width-1:0];
        end
        sum_ext = {sum_sat[ACC_width-1], sum_sat};

        // Adding half an LSB before the arithmetic shift rounds half toward +inf.
        round_term = (shift == '0) ? '0 : (W'(1) << (shift - SH_width'(1)));
        r_shift    = (sum_ext + round_term) >>> shift;
        r_relu     = (relu && r_shift[W-1]) ? '0 : r_shift;

        clamp_hi = (r_relu > OUT_MAX_W);
        clamp_lo = (r_relu < OUT_MIN_W);
        if (clamp_hi) begin
            res_data = OUT_MAX;
        end else if (clamp_lo) begin
            res_data = OUT_MIN;
        end else begin
            res_data = r_relu[OUT_width-1:0];
        end
        res_sat = ovf_base | sum_ovf | clamp_hi | clamp_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept && !last) begin
                state   <= BUSY;
                acc     <= sum_sat;
                acc_ovf <= ovf_base | sum_ovf;
            end
            // A new result may replace the one being drained in the same cycle.
            if (accept && last) begin
                state     <= EMPTY;
                acc       <= '0;
                acc_ovf   <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_sat   <= res_sat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum (17-bit accumulator build): directed spec cases plus a
// randomized stream with stalls scored against an arithmetic reference model.
module tb_psum_accum;

    localparam longint ACC_MAX = 65535;
    localparam longint ACC_MIN = -65536;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       product;
    logic              last;
    logic [4:0]        shift;
    logic              relu;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_sat;

    int vectors = 0;
    int miscompares = 0;

    longint m_acc = 0;
    bit     m_ovf = 0;

    always #5 clk = ~clk;

    psum_accum #(.A_width(8), .B_width(8), .ACC_width(17), .OUT_width(8), .SH_width(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .product(product), .last(last),
        .shift(shift), .relu(relu),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    // Reference: unbounded sum, clamp to accumulator range, then requantize.
    function automatic void model_beat(input longint p, input bit l, input int s, input bit r,
                                       output logic [7:0] res, output bit sat);
        longint sum;
        longint rr;
        bit     ovf;
        sum = m_acc + p;
        ovf = m_ovf;
        if (sum > ACC_MAX) begin sum = ACC_MAX; ovf = 1; end
        if (sum < ACC_MIN) begin sum = ACC_MIN; ovf = 1; end
        res = 8'd0;
        sat = 0;
        if (!l) begin
            m_acc = sum;
            m_ovf = ovf;
        end else begin
            m_acc = 0;
            m_ovf = 0;
            rr = (s == 0) ? sum : ((sum + (longint'(1) << (s - 1))) >>> s);
            if (r && rr < 0) rr = 0;
            sat = ovf;
            if (rr > 127)  begin rr = 127;  sat = 1; end
            if (rr < -128) begin rr = -128; sat = 1; end
            res = rr[7:0];
        end
    endfunction

    task automatic beat(input logic [15:0] p, input logic l, input logic [4:0] s, input logic r);
        in_valid = 1'b1; product = p; last = l; shift = s; relu = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 0; product = 0; last = 0; shift = 0; relu = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: out_valid=%b out_data=%0d out_sat=%b in_ready=%b, need 0 0 0 1",
                     out_valid, out_data, out_sat, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        beat(16'sd100, 0, 0, 0);
        beat(-16'sd30, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early: out_valid=%b before last, need 0", out_valid);
        end
        beat(16'sd7, 1, 0, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd77 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL basic: valid=%b data=%0d sat=%b, need 1 77 0", out_valid, $signed(out_data), out_sat);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse: out_valid=%b after drain, need 0", out_valid);
        end
    endtask

    task automatic test_rounding;
        logic [15:0] prods [4] = '{16'sd5, -16'sd5, 16'sd6, 16'h07FF};
        logic [4:0]  shs   [4] = '{5'd1, 5'd1, 5'd2, 5'd4};
        logic [7:0]  exps  [4] = '{8'sd3, -8'sd2, 8'sd2, 8'sd127};
        logic        sats  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            beat(prods[i], 1, shs[i], 0);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_sat !== sats[i]) begin
                miscompares++;
                $display("FAIL rounding[%0d]: valid=%b data=%0d sat=%b, need 1 %0d %b",
                         i, out_valid, $signed(out_data), out_sat, $signed(exps[i]), sats[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat_relu;
        beat(16'sd200, 0, 0, 0);
        beat(16'sd100, 1, 0, 0);
        vectors++;
        if (out_data !== 8'd127 || out_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_hi: data=%0d sat=%b, need 127 1", $signed(out_data), out_sat);
        end
        beat(-16'sd300, 1, 0, 0);
        vectors++;
        if (out_data !== 8'h80 || out_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_lo: data=%0d sat=%b, need -128 1", $signed(out_data), out_sat);
        end
        beat(-16'sd50, 1, 0, 1);
        vectors++;
        if (out_data !== 8'd0 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL relu: data=%0d sat=%b, need 0 0", $signed(out_data), out_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_acc_sat;
        repeat (5) beat(16'sd16384, 0, 5'd9, 0);
        beat(-16'sd1, 1, 5'd9, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd127 || out_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL acc_sat: valid=%b data=%0d sat=%b, need 1 127 1", out_valid, $signed(out_data), out_sat);
        end
        beat(16'sd1, 1, 0, 0);
        vectors++;
        if (out_data !== 8'd1 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL acc_sat_clear: data=%0d sat=%b, need 1 0", $signed(out_data), out_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        beat(16'sd10, 1, 0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; product = 16'sd55; last = 1'b1; shift = 0; relu = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_ready[%0d]: in_ready=%b, need 0", i, in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'd10) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%0d, need 1 10", i, out_valid, $signed(out_data));
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: in_ready=%b, need 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd55) begin
            miscompares++;
            $display("FAIL drain_reload: valid=%b data=%0d, need 1 55", out_valid, $signed(out_data));
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_once: out_valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_random_stream;
        logic [7:0] q_data [$];
        bit         q_sat  [$];
        logic [7:0] res;
        bit         sat;
        bit         taken = 1;
        int         accepted = 0;
        int         cycles = 0;
        m_acc = 0; m_ovf = 0;
        in_valid = 0;
        while (accepted < 1000 && cycles < 20000) begin
            if (!in_valid || taken) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) product = 16'($urandom);
                else product = 16'($signed(32'($urandom_range(0, 400))) - 200);
                last  = ($urandom_range(0, 3) == 0);
                shift = 5'($urandom_range(0, 10));
                relu  = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #2;
            vectors++;
            if (in_ready !== (!out_valid || out_ready)) begin
                miscompares++;
                $display("FAIL rand_in_ready: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q_data.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_spurious: out_valid with no result pending, data=%0d", $signed(out_data));
                end else begin
                    if (out_data !== q_data[0] || out_sat !== q_sat[0]) begin
                        miscompares++;
                        $display("FAIL rand_result: data=%0d sat=%b, need %0d %b",
                                 $signed(out_data), out_sat, $signed(q_data[0]), q_sat[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_sat.pop_front());
                end
            end
            taken = in_valid && in_ready;
            if (taken) begin
                model_beat(longint'($signed(product)), last, int'(shift), relu, res, sat);
                if (last) begin q_data.push_back(res); q_sat.push_back(sat); end
                accepted++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 0;
        vectors++;
        if (accepted < 1000) begin
            miscompares++;
            $display("FAIL rand_timeout: %0d beats accepted in %0d cycles, need 1000", accepted, cycles);
        end
        out_ready = 1'b1;
        #2;
        if (out_valid) begin
            vectors++;
            if (q_data.size() == 0 || out_data !== q_data[0] || out_sat !== q_sat[0]) begin
                miscompares++;
                $display("FAIL rand_final: data=%0d sat=%b pending=%0d", $signed(out_data), out_sat, q_data.size());
            end
            if (q_data.size() != 0) begin
                void'(q_data.pop_front());
                void'(q_sat.pop_front());
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (q_data.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_lost: %0d results never delivered, out_valid=%b, need 0 0", q_data.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        beat(16'sd1000, 0, 0, 0);
        beat(16'sd2000, 0, 0, 0);
        beat(16'sd3000, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: valid=%b data=%0d sat=%b during reset, need 0 0 0", out_valid, out_data, out_sat);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_spurious: out_valid=%b after release, need 0", out_valid);
        end
        beat(16'sd4, 1, 0, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd4 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b data=%0d sat=%b, need 1 4 0", out_valid, $signed(out_data), out_sat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_sat_relu();
        test_acc_sat();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
# psum_accum

Signed partial-sum accumulator and requantizer sitting directly downstream of the NPU's signed 8x8 multiplier (operated with TC=1). It accepts one PRODUCT per beat over a valid/ready handshake and accumulates a dot product until a beat marked `last`. It then rounds, right-shifts, optionally applies ReLU and saturates the sum to an output-width activation, which it holds in a registered output stage with its own valid/ready handshake.

## Interface
- `A_width`, default 8: multiplier A operand width.
- `B_width`, default 8: multiplier B operand width; product width P = A_width+B_width.
- `ACC_width`, default 32: accumulator width; must be greater than P.
- `OUT_width`, default 8: output activation width; must be less than ACC_width.
- `SH_width`, default 5: width of the shift control.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous and active-low.
- `in_valid` input 1: `product` beat valid.
- `in_ready` output 1: block can accept a beat.
- `product` input P: two's-complement product from the multiplier.
- `last` input 1: this beat ends the current dot product.
- `shift` input SH_width: arithmetic right-shift amount; sampled on the last beat.
- `relu` input 1: clamp negative results to 0; sampled on the last beat.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_data` output OUT_width: signed requantized result.
- `out_sat` output 1: an accumulator or output saturation occurred in this result.

## Operation
- Accept a beat when `in_valid & in_ready`. `in_ready = ~out_valid | out_ready`, a combinational pass-through of `out_ready`.
- Accumulator `acc` (ACC_width, signed) starts at 0. State machine:
  - EMPTY: no partial sum.
  - BUSY: at least one non-last beat has been accepted.
  - EMPTY→BUSY: non-last beat accepted.
  - BUSY→BUSY: further non-last beats.
  - Any state→EMPTY: last beat accepted.
- Each accepted beat computes `sum = acc + sign_extend(product)`.
  - If `sum` exceeds the ACC_width signed range, clamp it to the max/min and set the sticky `acc_ovf`.
  - A non-last beat writes `sum` into `acc`.
  - A last beat clears `acc` and `acc_ovf` to 0 and sends `sum` to requantization.
- Requantization on the last beat, in ACC_width+1 bits:
  - If `shift == 0`: `r = sum`, no rounding.
  - Otherwise: `r = (sum + 2^(shift-1)) >>> shift`, i.e. round half toward +inf.
  - If `relu` and `r < 0`: `r = 0`.
  - Saturate `r` to the OUT_width signed range: [-2^(OUT_width-1), 2^(OUT_width-1)-1].
  - `out_sat = acc_ovf_final | output_clamp`.
- Output register holds `out_data`/`out_sat`; `out_valid` stays high until `out_valid & out_ready`.
  - A simultaneous drain and new last beat reloads the register with the new result; `out_valid` stays high.
- A single-beat dot product (`last` on the first beat) is legal. The result is the requantized `product`.

## Timing
- Latency: a last beat accepted at edge N gives `out_valid=1` and the result visible after edge N; throughput is one beat per cycle.
- Reset values: `acc=0`, state EMPTY, `out_valid=0`, `out_data=0`, `out_sat=0`. `in_ready` follows its equation, so it is 1 after reset.
- Reset asserted mid-dot-product discards the partial sum and any pending output immediately. No spurious `out_valid` follows release.
- Output stalls (`out_ready=0` while `out_valid=1`) drop `in_ready`. `acc`, `out_data` and `out_sat` hold stable.
- `product`, `last`, `shift` and `relu` are ignored when no beat is accepted.

## Test plan
- Basic dot product: products 100, -30, 7 (7 with last), shift=0, relu=0 → one `out_valid` pulse with `out_data=77`, `out_sat=0`, one cycle after the last beat.
- Rounding: single-beat 5 with shift=1 → 3; single-beat -5 with shift=1 → -2; single-beat 6 with shift=2 → 2; 0x7FF with shift=4 → 127.
- Output saturation and ReLU: products 200, 100 (last), shift=0 → 127 with `out_sat=1`. Single-beat -300 → -128 with `out_sat=1`. Single-beat -50 with relu=1 → 0 with `out_sat=0`.
- Accumulator saturation: with ACC_width=17, 5x16384 then -1 (last), shift=9 → acc clamps at 65535, and the last-beat sum 65534 rounds to 128. Required `out_data=127`, `out_sat=1`. The next dot product, 1 (last), gives 1 with `out_sat=0`.
- Backpressure: hold `out_ready=0` after a result while `in_valid=1` streams → `in_ready=0`, with `out_data` and the held stream beat unchanged for 5 cycles. Raise `out_ready` → drain and same-cycle acceptance with no lost or duplicated beat. Check against a reference model over 1000 random beats with random stalls.
- Reset mid-operation: accept 3 non-last beats, pulse `rst_n` low asynchronously, then send 4 (last) → `out_data=4`, proving `acc` was cleared.
